// File: rtl/fsm_control_pkg.sv
// Shared constants and state encoding for the FIFO-switch control FSM.
// The arbiter and FIFOs import this package for the threshold width.
package fsm_control_pkg;

  localparam int FSM_NUM_FIFO   = 8;
  localparam int FSM_UMBRAL_W   = 3;
  localparam int FSM_DEFAULT_AF = 6;
  localparam int FSM_DEFAULT_AE = 1;

  typedef enum logic [2:0] {
    RESET  = 3'd0,
    INIT   = 3'd1,
    IDLE   = 3'd2,
    ACTIVE = 3'd3,
    ERROR  = 3'd4
  } state_t;

endpackage

// File: rtl/fsm_control_umbral_check.sv
// Combinational threshold validator: almost-empty must sit strictly below a
// non-zero almost-full. Also instantiated by the FIFO benches.
module umbral_check #(
  parameter int W = 3
) (
  input  logic [W-1:0] af,
  input  logic [W-1:0] ae,
  output logic         valid
);

  assign valid = (ae < af) && (af != '0);

endmodule

// File: rtl/fsm_control.sv
// Bring-up / configuration / error control FSM for the 4-in/4-out FIFO switch.
// Every output is a register updated on the same edge as the state.
module fsm_control
  import fsm_control_pkg::*;
#(
  parameter int NUM_FIFO   = FSM_NUM_FIFO,
  parameter int UMBRAL_W   = FSM_UMBRAL_W,
  parameter int DEFAULT_AF = FSM_DEFAULT_AF,
  parameter int DEFAULT_AE = FSM_DEFAULT_AE
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                init,
  input  logic [UMBRAL_W-1:0] umbral_af_in,
  input  logic [UMBRAL_W-1:0] umbral_ae_in,
  input  logic [NUM_FIFO-1:0] fifo_empty,
  input  logic [NUM_FIFO-1:0] fifo_error,
  output logic [2:0]          state,
  output logic [UMBRAL_W-1:0] umbral_af,
  output logic [UMBRAL_W-1:0] umbral_ae,
  output logic                arb_en,
  output logic                idle_out,
  output logic                error_out,
  output logic [NUM_FIFO-1:0] error_src,
  output logic                cfg_load
);

  state_t              state_reg, state_next;
  logic [UMBRAL_W-1:0] af_reg, af_next;
  logic [UMBRAL_W-1:0] ae_reg, ae_next;
  logic                arb_en_reg, arb_en_next;
  logic                idle_reg, idle_next;
  logic                error_reg, error_next;
  logic [NUM_FIFO-1:0] error_src_reg, error_src_next;
  logic                cfg_load_reg, cfg_load_next;

  logic cfg_valid;
  logic all_empty;
  logic any_error;

  assign all_empty = &fifo_empty;
  assign any_error = |fifo_error;

  umbral_check #(
    .W(UMBRAL_W)
  ) u_umbral_check (
    .af   (umbral_af_in),
    .ae   (umbral_ae_in),
    .valid(cfg_valid)
  );

  always_comb begin
    state_next    = state_reg;
    af_next       = af_reg;
    ae_next       = ae_reg;
    cfg_load_next = 1'b0;

    case (state_reg)
      RESET: state_next = INIT;
      INIT: begin
        if (any_error) begin
          state_next = ERROR;
        end else if (!init && cfg_valid) begin
          af_next       = umbral_af_in;
          ae_next       = umbral_ae_in;
          cfg_load_next = 1'b1;
          state_next    = all_empty ? IDLE : ACTIVE;
        end
      end
      IDLE, ACTIVE: begin
        if (any_error) begin
          state_next = ERROR;
        end else if (init) begin
          state_next = INIT;
        end else begin
          state_next = all_empty ? IDLE : ACTIVE;
        end
      end
      ERROR: state_next = ERROR;
      // Codes 5-7 can only appear through upset; recover via RESET.
      default: state_next = RESET;
    endcase

    // Outputs are a function of the state being entered so they stay aligned.
    arb_en_next    = (state_next == IDLE) || (state_next == ACTIVE);
    idle_next      = (state_next == IDLE);
    error_next     = (state_next == ERROR);
    error_src_next = error_src_reg | ((state_next == ERROR) ? fifo_error : '0);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg     <= RESET;
      af_reg        <= UMBRAL_W'(DEFAULT_AF);
      ae_reg        <= UMBRAL_W'(DEFAULT_AE);
      arb_en_reg    <= 1'b0;
      idle_reg      <= 1'b0;
      error_reg     <= 1'b0;
      error_src_reg <= '0;
      cfg_load_reg  <= 1'b0;
    end else begin
      state_reg     <= state_next;
      af_reg        <= af_next;
      ae_reg        <= ae_next;
      arb_en_reg    <= arb_en_next;
      idle_reg      <= idle_next;
      error_reg     <= error_next;
      error_src_reg <= error_src_next;
      cfg_load_reg  <= cfg_load_next;
    end
  end

  assign state     = state_reg;
  assign umbral_af = af_reg;
  assign umbral_ae = ae_reg;
  assign arb_en    = arb_en_reg;
  assign idle_out  = idle_reg;
  assign error_out = error_reg;
  assign error_src = error_src_reg;
  assign cfg_load  = cfg_load_reg;

endmodule

// File: tb/tb_fsm_control.sv
// Scoreboard bench for fsm_control: a rule-level reference model predicts the
// output snapshot after each edge; a monitor compares it one step after the edge.
module tb_fsm_control;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       init = 1'b0;
  logic [2:0] af_in = 3'd0;
  logic [2:0] ae_in = 3'd0;
  logic [7:0] empty = 8'hFF;
  logic [7:0] ferr = 8'h00;

  logic [2:0] state;
  logic [2:0] umbral_af, umbral_ae;
  logic       arb_en, idle_out, error_out, cfg_load;
  logic [7:0] error_src;

  fsm_control dut (
    .clk         (clk),
    .reset       (rst_n),
    .init        (init),
    .umbral_af_in(af_in),
    .umbral_ae_in(ae_in),
    .fifo_empty  (empty),
    .fifo_error  (ferr),
    .state       (state),
    .umbral_af   (umbral_af),
    .umbral_ae   (umbral_ae),
    .arb_en      (arb_en),
    .idle_out    (idle_out),
    .error_out   (error_out),
    .error_src   (error_src),
    .cfg_load    (cfg_load)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] st;
    logic [2:0] af;
    logic [2:0] ae;
    logic       arb;
    logic       idle;
    logic       er;
    logic [7:0] src;
    logic       cfg;
  } snap_t;

  snap_t exp_q[$];
  snap_t model;
  int    checks = 0;
  int    failures = 0;
  int    txn = 0;

  function automatic snap_t reset_snap();
    snap_t s;
    s    = '0;
    s.af = 3'd6;
    s.ae = 3'd1;
    return s;
  endfunction

  // Behavioural rules: 0=RESET 1=INIT 2=IDLE 3=ACTIVE 4=ERROR.
  function automatic snap_t step(snap_t c, logic rn, logic ini, logic [2:0] a,
                                 logic [2:0] e, logic [7:0] emp, logic [7:0] fe);
    snap_t n;
    if (!rn) return reset_snap();
    n     = c;
    n.cfg = 1'b0;
    if (c.st == 3'd0) begin
      n.st = 3'd1;
    end else if (c.st == 3'd1) begin
      if (fe != 0) n.st = 3'd4;
      else if (!ini && (e < a) && (a != 0)) begin
        n.af  = a;
        n.ae  = e;
        n.cfg = 1'b1;
        n.st  = (emp == 8'hFF) ? 3'd2 : 3'd3;
      end
    end else if (c.st == 3'd2 || c.st == 3'd3) begin
      if (fe != 0) n.st = 3'd4;
      else if (ini) n.st = 3'd1;
      else n.st = (emp == 8'hFF) ? 3'd2 : 3'd3;
    end
    if (n.st == 3'd4) n.src = c.src | fe;
    n.arb  = (n.st == 3'd2) || (n.st == 3'd3);
    n.idle = (n.st == 3'd2);
    n.er   = (n.st == 3'd4);
    return n;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h t=%0t", name, got, want, $time);
    end
  endtask

  task automatic cycle(input logic rn, input logic ini, input logic [2:0] a,
                       input logic [2:0] e, input logic [7:0] emp, input logic [7:0] fe);
    @(negedge clk);
    rst_n = rn;
    init  = ini;
    af_in = a;
    ae_in = e;
    empty = emp;
    ferr  = fe;
    model = step(model, rn, ini, a, e, emp, fe);
    exp_q.push_back(model);
  endtask

  // Assert reset between edges and check that outputs clear with no clock.
  task automatic async_reset();
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_state", 32'(state), 32'd0);
    chk("async_af", 32'(umbral_af), 32'd6);
    chk("async_ae", 32'(umbral_ae), 32'd1);
    chk("async_arb_en", 32'(arb_en), 32'd0);
    chk("async_idle", 32'(idle_out), 32'd0);
    chk("async_error", 32'(error_out), 32'd0);
    chk("async_src", 32'(error_src), 32'd0);
    chk("async_cfg", 32'(cfg_load), 32'd0);
    model = reset_snap();
  endtask

  initial begin : monitor
    snap_t want, got;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        want = exp_q.pop_front();
        got  = {state, umbral_af, umbral_ae, arb_en, idle_out, error_out, error_src, cfg_load};
        checks++;
        txn++;
        if (got !== want) begin
          failures++;
          $display("FAIL snapshot txn=%0d got st=%0d af=%0d ae=%0d arb=%0b idle=%0b err=%0b src=%h cfg=%0b expected st=%0d af=%0d ae=%0d arb=%0b idle=%0b err=%0b src=%h cfg=%0b",
                   txn, got.st, got.af, got.ae, got.arb, got.idle, got.er, got.src, got.cfg,
                   want.st, want.af, want.ae, want.arb, want.idle, want.er, want.src, want.cfg);
        end else begin
          $display("txn %0d st=%0d af=%0d ae=%0d arb=%0b idle=%0b err=%0b src=%h cfg=%0b ok",
                   txn, got.st, got.af, got.ae, got.arb, got.idle, got.er, got.src, got.cfg);
        end
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "bench timed out");
  end

  initial begin : driver
    logic       ini;
    logic [7:0] emp, fe;
    model = reset_snap();
    #1;
    rst_n = 1'b0;
    #1;
    chk("por_state", 32'(state), 32'd0);
    chk("por_af", 32'(umbral_af), 32'd6);
    chk("por_ae", 32'(umbral_ae), 32'd1);
    chk("por_src", 32'(error_src), 32'd0);

    cycle(1'b0, 1'b0, 3'd0, 3'd0, 8'hFF, 8'h00);
    cycle(1'b1, 1'b0, 3'd2, 3'd3, 8'hFF, 8'h00);            // -> INIT
    repeat (3) cycle(1'b1, 1'b0, 3'd2, 3'd3, 8'hFF, 8'h00); // invalid: stay
    cycle(1'b1, 1'b0, 3'd2, 3'd1, 8'hFF, 8'h00);            // commit 2/1
    cycle(1'b1, 1'b0, 3'd2, 3'd1, 8'hFF, 8'h00);
    cycle(1'b1, 1'b0, 3'd0, 3'd0, 8'hFE, 8'h00);            // -> ACTIVE
    cycle(1'b1, 1'b0, 3'd0, 3'd0, 8'hFF, 8'h00);            // -> IDLE
    cycle(1'b1, 1'b1, 3'd5, 3'd2, 8'hFF, 8'h00);            // -> INIT
    cycle(1'b1, 1'b1, 3'd5, 3'd2, 8'hFF, 8'h00);            // held by init
    cycle(1'b1, 1'b0, 3'd5, 3'd2, 8'hFF, 8'h00);            // commit 5/2 -> IDLE
    cycle(1'b1, 1'b0, 3'd5, 3'd2, 8'hFF, 8'h00);
    cycle(1'b1, 1'b0, 3'd5, 3'd2, 8'hFE, 8'h00);            // -> ACTIVE
    async_reset();
    cycle(1'b0, 1'b0, 3'd5, 3'd2, 8'hFE, 8'h00);
    cycle(1'b1, 1'b0, 3'd5, 3'd2, 8'hFE, 8'h00);            // -> INIT
    cycle(1'b1, 1'b0, 3'd5, 3'd2, 8'hFE, 8'h00);            // commit -> ACTIVE
    cycle(1'b1, 1'b0, 3'd5, 3'd2, 8'hFE, 8'h04);            // -> ERROR
    cycle(1'b1, 1'b0, 3'd5, 3'd2, 8'hFE, 8'h20);
    repeat (3) cycle(1'b1, 1'b1, 3'd5, 3'd2, 8'hFF, 8'h00);
    @(posedge clk);
    #2;
    chk("error_src_24", 32'(error_src), 32'h24);
    chk("error_sticky_state", 32'(state), 32'd4);
    cycle(1'b0, 1'b0, 3'd5, 3'd2, 8'hFE, 8'h00);
    cycle(1'b1, 1'b0, 3'd5, 3'd2, 8'hFE, 8'h00);
    cycle(1'b1, 1'b0, 3'd5, 3'd2, 8'hFE, 8'h00);
    cycle(1'b1, 1'b1, 3'd3, 3'd1, 8'hFE, 8'h01);            // error beats init

    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 79) == 0) begin
        async_reset();
        cycle(1'b0, 1'b0, 3'd0, 3'd0, 8'hFF, 8'h00);
      end
      ini = ($urandom_range(0, 7) == 0);
      emp = ($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'hFF;
      fe  = ($urandom_range(0, 49) == 0) ? (8'h01 << $urandom_range(0, 7)) : 8'h00;
      cycle(($urandom_range(0, 59) != 0), ini, 3'($urandom), 3'($urandom), emp, fe);
    end

    @(posedge clk);
    #2;
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
